// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - control-unit to datapath signal bundle
//
// master : control unit (reads opcode/zero, drives enables, selects, debug)
// slave  : datapath / bench (drives opcode/zero, observes everything else)
//   opcode[3:0] instruction[15:12]      zero        ALU zero flag
//   pcWrite, pcSrc[1:0], irWrite        PC / IR control
//   aluSrcB, aluOp[1:0]                 ALU operand B select, ALU function
//   memRead, memWrite                   data-memory enables
//   regWrite, regDst, memToReg          register-file write control
//   state[2:0], halted, retired[15:0]   debug / observation
interface multicycle_control_unit_if;
    logic [3:0]  opcode;
    logic        zero;
    logic        pcWrite;
    logic [1:0]  pcSrc;
    logic        irWrite;
    logic        aluSrcB;
    logic [1:0]  aluOp;
    logic        memRead;
    logic        memWrite;
    logic        regWrite;
    logic        regDst;
    logic        memToReg;
    logic [2:0]  state;
    logic        halted;
    logic [15:0] retired;

    modport master (
        input  opcode, zero,
        output pcWrite, pcSrc, irWrite, aluSrcB, aluOp, memRead, memWrite,
               regWrite, regDst, memToReg, state, halted, retired
    );

    modport slave (
        output opcode, zero,
        input  pcWrite, pcSrc, irWrite, aluSrcB, aluOp, memRead, memWrite,
               regWrite, regDst, memToReg, state, halted, retired
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - fetch/decode/exec/mem/wb control FSM for the 16-bit multi-cycle CPU
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high; forces every output to 0 while high
//   bus    master side of multicycle_control_unit_if (opcode/zero in,
//          datapath enables, mux selects, state, halted, retired out)
module multicycle_control_unit (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_control_unit_if.master     bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_BNE  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] retired_q, retired_d;
    logic        retire;

    logic        pc_write, ir_write, alu_src_b, mem_read, mem_write;
    logic        reg_write, reg_dst, mem_to_reg, halted;
    logic [1:0]  pc_src, alu_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= 4'h0;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        op_d       = op_q;
        retire     = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        ir_write   = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = 2'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                // Later states work from op_q so a changing IR cannot disturb them.
                op_d = bus.opcode;
                case (bus.opcode)
                    4'h0, 4'h1, 4'h2, 4'h3,
                    OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: state_d = S_EXEC;
                    OP_JMP: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                        retire   = 1'b1;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end
                    default: retire = 1'b1;     // illegal opcode acts as NOP
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    4'h0, 4'h1, 4'h2, 4'h3: begin
                        alu_op  = op_q[1:0];    // R-type opcode doubles as ALU function
                        state_d = S_WB;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        alu_src_b = 1'b1;
                        alu_op    = 2'd1;
                        state_d   = (op_q == OP_ADDI) ? S_WB : S_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_op   = 2'd2;
                        pc_src   = 2'd1;
                        // Mealy: branch decision taken from this cycle's zero flag.
                        pc_write = (op_q == OP_BEQ) ? bus.zero : ~bus.zero;
                        retire   = 1'b1;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (op_q == OP_LW) begin
                    mem_read = 1'b1;
                    state_d  = S_WB;
                end else if (op_q == OP_SW) begin
                    mem_write = 1'b1;
                    retire    = 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op_q[3:2] == 2'b00);
                mem_to_reg = (op_q == OP_LW);
                retire     = 1'b1;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase

        retired_d = retired_q + {15'd0, retire};
    end

    // Reset masks every output so nothing is enabled in an aborting cycle.
    assign bus.pcWrite  = pc_write   & ~reset;
    assign bus.pcSrc    = reset ? 2'd0 : pc_src;
    assign bus.irWrite  = ir_write   & ~reset;
    assign bus.aluSrcB  = alu_src_b  & ~reset;
    assign bus.aluOp    = reset ? 2'd0 : alu_op;
    assign bus.memRead  = mem_read   & ~reset;
    assign bus.memWrite = mem_write  & ~reset;
    assign bus.regWrite = reg_write  & ~reset;
    assign bus.regDst   = reg_dst    & ~reset;
    assign bus.memToReg = mem_to_reg & ~reset;
    assign bus.halted   = halted     & ~reset;
    assign bus.state    = reset ? 3'd0 : state_q;
    assign bus.retired  = reset ? 16'h0000 : retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_unit_if bus ();

    multicycle_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // {pcWrite, pcSrc[1:0], irWrite, aluSrcB, aluOp[1:0], memRead, memWrite, regWrite, regDst, memToReg}
    wire [11:0] ctl = {bus.pcWrite, bus.pcSrc, bus.irWrite, bus.aluSrcB, bus.aluOp,
                       bus.memRead, bus.memWrite, bus.regWrite, bus.regDst, bus.memToReg};

    // Leaves the bench at a falling edge with reset just released; DUT is in FETCH.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.opcode = 4'h0;
        bus.zero = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.opcode = 4'h1;
        bus.zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({ctl, bus.state, bus.halted, bus.retired} !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d: got ctl=%h state=%0d halted=%b retired=%h want all 0",
                         i, ctl, bus.state, bus.halted, bus.retired);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.state !== 3'd0 || ctl !== 12'h900) begin
            errors++;
            $display("FAIL reset_first_fetch: got state=%0d ctl=%h want state=0 ctl=900", bus.state, ctl);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 3'd1 || ctl !== 12'h000) begin
            errors++;
            $display("FAIL reset_then_decode: got state=%0d ctl=%h want state=1 ctl=000", bus.state, ctl);
        end
    endtask

    task automatic test_add_lw_sw();
        // LW opcode is changed to OR after DECODE; the latched opcode must win.
        logic [3:0]  op [13] = '{4'h1, 4'h1, 4'h1, 4'h1,
                                 4'h5, 4'h5, 4'h3, 4'h3, 4'h3,
                                 4'h6, 4'h6, 4'h6, 4'h6};
        logic [2:0]  st [13] = '{3'd0, 3'd1, 3'd2, 3'd4,
                                 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
                                 3'd0, 3'd1, 3'd2, 3'd3};
        logic [11:0] ex [13] = '{12'h900, 12'h000, 12'h020, 12'h006,
                                 12'h900, 12'h000, 12'h0A0, 12'h010, 12'h005,
                                 12'h900, 12'h000, 12'h0A0, 12'h008};
        int reg_writes = 0;
        int mem_writes = 0;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            bus.opcode = op[i];
            #1;
            reg_writes += int'(bus.regWrite);
            mem_writes += int'(bus.memWrite);
            checks++;
            if (bus.state !== st[i] || ctl !== ex[i]) begin
                errors++;
                $display("FAIL add_lw_sw cyc %0d: got state=%0d ctl=%h want state=%0d ctl=%h",
                         i, bus.state, ctl, st[i], ex[i]);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (bus.retired !== 16'd3 || bus.state !== 3'd0) begin
            errors++;
            $display("FAIL add_lw_sw_retired: got retired=%0d state=%0d want retired=3 state=0",
                     bus.retired, bus.state);
        end
        checks++;
        if (reg_writes != 2 || mem_writes != 1) begin
            errors++;
            $display("FAIL add_lw_sw_pulses: got regWrite=%0d memWrite=%0d want 2 and 1",
                     reg_writes, mem_writes);
        end
    endtask

    task automatic test_branch();
        logic [3:0]  op [12] = '{4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7,
                                 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8};
        logic        zf [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [11:0] ex [12] = '{12'h900, 12'h000, 12'hA40, 12'h900, 12'h000, 12'h240,
                                 12'h900, 12'h000, 12'h240, 12'h900, 12'h000, 12'hA40};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            bus.opcode = op[i];
            bus.zero = zf[i];
            #1;
            checks++;
            if (bus.state !== 3'(i % 3) || ctl !== ex[i]) begin
                errors++;
                $display("FAIL branch cyc %0d: got state=%0d ctl=%h want state=%0d ctl=%h",
                         i, bus.state, ctl, i % 3, ex[i]);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (bus.retired !== 16'd4 || bus.state !== 3'd0) begin
            errors++;
            $display("FAIL branch_retired: got retired=%0d state=%0d want retired=4 state=0",
                     bus.retired, bus.state);
        end
    endtask

    task automatic test_jmp_illegal();
        logic [3:0]  op [4] = '{4'h9, 4'h9, 4'hC, 4'hC};
        logic [2:0]  st [4] = '{3'd0, 3'd1, 3'd0, 3'd1};
        logic [11:0] ex [4] = '{12'h900, 12'hC00, 12'h900, 12'h000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.opcode = op[i];
            #1;
            checks++;
            if (bus.state !== st[i] || ctl !== ex[i]) begin
                errors++;
                $display("FAIL jmp_illegal cyc %0d: got state=%0d ctl=%h want state=%0d ctl=%h",
                         i, bus.state, ctl, st[i], ex[i]);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (bus.retired !== 16'd2 || bus.state !== 3'd0) begin
            errors++;
            $display("FAIL jmp_illegal_retired: got retired=%0d state=%0d want retired=2 state=0",
                     bus.retired, bus.state);
        end
    endtask

    task automatic test_halt();
        int bad = 0;
        do_reset();
        bus.opcode = 4'hF;
        #1;
        checks++;
        if (bus.state !== 3'd0 || ctl !== 12'h900) begin
            errors++;
            $display("FAIL halt_fetch: got state=%0d ctl=%h want state=0 ctl=900", bus.state, ctl);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 3'd1 || ctl !== 12'h000 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_decode: got state=%0d ctl=%h halted=%b want state=1 ctl=000 halted=0",
                     bus.state, ctl, bus.halted);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.opcode = 4'(i);
            #1;
            if (bus.state !== 3'd5 || bus.halted !== 1'b1 || ctl !== 12'h000 || bus.retired !== 16'd1)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt_park: got %0d bad cycles of 20 (last state=%0d halted=%b ctl=%h retired=%0d) want 0",
                     bad, bus.state, bus.halted, ctl, bus.retired);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.state !== 3'd0 || bus.halted !== 1'b0 || ctl !== 12'h000) begin
            errors++;
            $display("FAIL halt_reset_cycle: got state=%0d halted=%b ctl=%h want 0 0 000",
                     bus.state, bus.halted, ctl);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.state !== 3'd0 || ctl !== 12'h900 || bus.retired !== 16'd0) begin
            errors++;
            $display("FAIL halt_after_reset: got state=%0d ctl=%h retired=%0d want state=0 ctl=900 retired=0",
                     bus.state, ctl, bus.retired);
        end
    endtask

    task automatic test_wrap_and_abort();
        do_reset();
        bus.opcode = 4'h1;
        force dut.retired_q = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        release dut.retired_q;
        #1;
        checks++;
        if (bus.state !== 3'd2 || bus.retired !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload: got state=%0d retired=%h want state=2 retired=ffff",
                     bus.state, bus.retired);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 3'd0 || bus.retired !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_retired: got state=%0d retired=%h want state=0 retired=0000",
                     bus.state, bus.retired);
        end
        // LW, then abort it with reset during MEM.
        bus.opcode = 4'h5;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 3'd3 || ctl !== 12'h010) begin
            errors++;
            $display("FAIL abort_mem: got state=%0d ctl=%h want state=3 ctl=010", bus.state, ctl);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ctl !== 12'h000 || bus.state !== 3'd0) begin
            errors++;
            $display("FAIL abort_reset_cycle: got state=%0d ctl=%h want state=0 ctl=000", bus.state, ctl);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.state !== 3'd0 || ctl !== 12'h900 || bus.retired !== 16'd0) begin
            errors++;
            $display("FAIL abort_after: got state=%0d ctl=%h retired=%0d want state=0 ctl=900 retired=0",
                     bus.state, ctl, bus.retired);
        end
    endtask

    initial begin
        bus.opcode = 4'h0;
        bus.zero = 1'b0;
        test_reset();
        test_add_lw_sw();
        test_branch();
        test_jmp_illegal();
        test_halt();
        test_wrap_and_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
